// File: rtl/user_wb_responder.sv
// Wishbone classic responder: scratch words, ID, cycle counter, latched IRQ.
// Latency: ack WAIT_STATES+1 cycles after the request is sampled. An aborted request gets no ack.
module user_wb_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hCA5E_0001
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        irq_event_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  idx_q;
    logic        hi_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;

    logic [31:0] scratch [8];
    logic [31:0] cycle_cnt;
    logic        irq_status, irq_enable;

    logic        req, hit, go_ack, latch;
    logic [3:0]  t_idx, t_sel;
    logic        t_hi, t_we;
    logic [31:0] t_dat, rd_dat;
    logic        wr_en, w1c;

    assign req = wb_cyc_i & wb_stb_i;
    assign hit = (wb_adr_i & ADDR_MASK) == BASE_ADDR;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        go_ack  = 1'b0;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && hit) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d = S_ACK;
                    go_ack  = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the sampling edge, so use live bus values.
    always_comb begin
        if (state_q == S_IDLE) begin
            t_idx = wb_adr_i[5:2];
            t_hi  = |(wb_adr_i & ~ADDR_MASK & 32'hFFFF_FFC0);
            t_we  = wb_we_i;
            t_sel = wb_sel_i;
            t_dat = wb_dat_i;
        end else begin
            t_idx = idx_q;
            t_hi  = hi_q;
            t_we  = we_q;
            t_sel = sel_q;
            t_dat = dat_q;
        end
    end

    assign wr_en = go_ack & t_we & ~t_hi;
    assign w1c   = wr_en & (t_idx == 4'd10) & t_sel[0] & t_dat[0];

    always_comb begin
        rd_dat = '0;
        if (!t_hi) begin
            if (!t_idx[3]) begin
                rd_dat = scratch[t_idx[2:0]];
            end else begin
                case (t_idx[2:0])
                    3'd0:    rd_dat = ID_VALUE;
                    3'd1:    rd_dat = cycle_cnt;
                    3'd2:    rd_dat = {31'b0, irq_status};
                    3'd3:    rd_dat = {31'b0, irq_enable};
                    default: rd_dat = '0;
                endcase
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            idx_q    <= '0;
            hi_q     <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            dat_q    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            wb_ack_o <= go_ack;
            wb_dat_o <= go_ack ? rd_dat : 32'd0;
            if (latch) begin
                idx_q <= wb_adr_i[5:2];
                hi_q  <= |(wb_adr_i & ~ADDR_MASK & 32'hFFFF_FFC0);
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            for (int i = 0; i < 8; i++) scratch[i] <= '0;
            cycle_cnt  <= '0;
            irq_status <= 1'b0;
            irq_enable <= 1'b0;
        end else begin
            cycle_cnt  <= cycle_cnt + 32'd1;
            // A new event wins over a simultaneous clear.
            irq_status <= irq_event_i | (irq_status & ~w1c);
            if (wr_en && !t_idx[3]) begin
                for (int b = 0; b < 4; b++)
                    if (t_sel[b]) scratch[t_idx[2:0]][8*b +: 8] <= t_dat[8*b +: 8];
            end
            if (wr_en && t_idx == 4'd11 && t_sel[0])
                irq_enable <= t_dat[0];
        end
    end

    assign irq_o = irq_status & irq_enable;

endmodule

// File: doc/user_wb_responder.md
# user_wb_responder

Wishbone classic responder for the user project area, answering the management SoC's exported user wishbone bus (cyc/stb/we/sel/adr/dat out, ack/dat back). It decodes one address window and provides eight byte-writable scratch words, a read-only ID word, a free-running cycle counter, and a latched interrupt with enable. Programmable wait states exercise the initiator's ack-wait path. The interrupt output drives one of the user IRQ lines back to the CPU.

## Interface
- BASE_ADDR, 32'h3000_0000, window base; must be aligned to ADDR_MASK
- ADDR_MASK, 32'hFFFF_0000, window match mask; hit when (wb_adr_i & ADDR_MASK) == BASE_ADDR
- WAIT_STATES, 1, extra cycles before ack (0..15)
- ID_VALUE, 32'hCA5E_0001, value returned at offset 0x20

- core_clk  in  1  clock
- core_rstn  in  1  reset; asynchronous, active-low
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_sel_i  in  4  byte lane enables
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  single-cycle acknowledge
- wb_dat_o  out  32  read data; valid only while wb_ack_o = 1, else 0
- irq_event_i  in  1  one-cycle event pulse; sets IRQ status
- irq_o  out  1  status[0] & enable[0]

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: wb_cyc_i & wb_stb_i & window hit -> latch adr[5:2], we, sel, dat. Go to WAIT with wait counter = WAIT_STATES-1, or to ACK when WAIT_STATES = 0. A miss is ignored: no ack, stay IDLE.
- WAIT: decrement the counter; at 0 go to ACK. If wb_cyc_i or wb_stb_i drops, abort to IDLE. An aborted transaction has no ack, no write, and no side effect.
- ACK: wb_ack_o = 1 for exactly one cycle, then IDLE. A request still present in IDLE is treated as a new transaction.
- Writes commit on the edge that enters ACK. Read data is captured on the same edge.
- Register map, word offsets:
  - 0x00–0x1C: scratch[0..7], R/W; each byte is written only if its wb_sel_i bit is set.
  - 0x20: ID_VALUE, RO.
  - 0x24: cycle counter, RO. 32-bit, increments every clock, wraps 0xFFFF_FFFF -> 0.
  - 0x28: IRQ status bit0, RO except write-1-to-clear. Requires sel[0] and dat[0] = 1. Bits 31:1 read 0.
  - 0x2C: IRQ enable bit0, R/W via sel[0]. Bits 31:1 read 0.
  - 0x30–window end: acked, read 0, writes ignored.
- Writes to RO locations are acked and ignored.
- Reads have no side effects. Read data is taken from the register state before any same-edge update.
- irq_event_i = 1 sets status on the next edge. Simultaneous event and W1C clear: set wins, status stays 1.
- irq_o is combinational from the status and enable flops. No glitches on inputs.
- Reset values: FSM IDLE, wb_ack_o 0, wb_dat_o 0, scratch 0, counter 0, status 0, enable 0, irq_o 0.
- Reset mid-transaction: return to IDLE immediately. No ack, pending write dropped.

## Timing
- Latency: request sampled at edge N -> wb_ack_o high during cycle N+1+WAIT_STATES. With WAIT_STATES = 1, ack appears 2 cycles after the request is sampled.
- wb_ack_o and wb_dat_o are registered outputs; no combinational path from wb_* inputs.
- Back-to-back: minimum spacing is one IDLE cycle after ACK. Throughput is one transaction per WAIT_STATES+2 cycles.
- Counter read returns its value at the edge entering ACK.
- IRQ: event at edge N -> irq_o high after edge N if enabled. W1C at the ACK-entry edge -> irq_o low the same cycle the ack is visible.

## Test plan
- Reset, then read 0x3000_0020 -> ack 2 cycles after the sampled strobe, data 0xCA5E_0001. Read 0x3000_0000 -> 0.
- Write 0x3000_0004 = 0xDEAD_BEEF with sel = 4'b0101, then read back -> 0x00AD_00EF. Full-sel write 0x1234_5678, then read -> 0x1234_5678.
- Access 0x3001_0000 (window miss) -> no ack for 20 cycles. Access 0x3000_0040 -> ack with read data 0, and scratch values unchanged.
- Start a write to 0x3000_0008 with WAIT_STATES = 3; drop cyc after 2 cycles -> no ack, scratch[2] still 0. Assert core_rstn low during WAIT -> ack 0, all registers reset.
- Write 1 to enable (0x2C), pulse irq_event_i -> irq_o = 1. Write 1 to 0x28 -> irq_o = 0. W1C coincident with an irq_event_i pulse -> status reads 1.
- Read counter twice with a known gap of G cycles -> values differ by exactly G. Force the counter to 0xFFFF_FFFE, run 3 cycles -> reads 0x0000_0001.
